// File: rtl/iir_tap_sequencer.sv
// Stereo front/back-end sequencer for the shared IIR tap cascade: widens a PCM pair,
// strobes left then right through the taps, and narrows the results. Macro: IIR_SEQ_ROUND_EN.
module iir_tap_sequencer #(
  parameter int SAMPLE_W  = 16,
  parameter int FRAC_BITS = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                tap_ce,
  output logic                tap_ch,
  output logic [39:0]         tap_x,
  input  logic [39:0]         tap_y,
  output logic [SAMPLE_W-1:0] out_l,
  output logic [SAMPLE_W-1:0] out_r,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int YW    = 40;
  localparam int VW    = YW - FRAC_BITS;
  localparam int EXT_W = YW - FRAC_BITS - SAMPLE_W;

  typedef enum logic [2:0] {
    IDLE,
    L_STEP,
    L_CAP,
    R_STEP,
    R_CAP,
    OUT
  } state_t;

  state_t              state_q, state_d;
  logic                tap_ch_q;
  logic [SAMPLE_W-1:0] smp_l_q, smp_l_d;
  logic [SAMPLE_W-1:0] smp_r_q, smp_r_d;
  logic [SAMPLE_W-1:0] out_l_q, out_l_d;
  logic [SAMPLE_W-1:0] out_r_q, out_r_d;

  logic                  pcm_rnd;
  logic [VW:0]           pcm_sum;
  logic [VW-SAMPLE_W+1:0] sat_top;
  logic [SAMPLE_W-1:0]   pcm_val;
  logic                  unused_tap_lsbs;

  function automatic logic [YW-1:0] widen(input logic [SAMPLE_W-1:0] s);
    return {{EXT_W{s[SAMPLE_W-1]}}, s, {FRAC_BITS{1'b0}}};
  endfunction

`ifdef IIR_SEQ_ROUND_EN
  assign pcm_rnd         = tap_y[FRAC_BITS-1];
  assign unused_tap_lsbs = ^tap_y[FRAC_BITS-2:0];
`else
  assign pcm_rnd         = 1'b0;
  assign unused_tap_lsbs = ^tap_y[FRAC_BITS-1:0];
`endif

  // One guard bit above the integer part keeps the rounding increment from wrapping.
  always_comb begin
    pcm_sum = {tap_y[YW-1], tap_y[YW-1:FRAC_BITS]} + {{VW{1'b0}}, pcm_rnd};
    sat_top = pcm_sum[VW:SAMPLE_W-1];
    if ((&sat_top) || (~|sat_top)) begin
      pcm_val = pcm_sum[SAMPLE_W-1:0];
    end else if (pcm_sum[VW]) begin
      pcm_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      pcm_val = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    smp_l_d   = smp_l_q;
    smp_r_d   = smp_r_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    tap_ce    = 1'b0;
    tap_ch    = tap_ch_q;
    tap_x     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = reset_n;
        if (in_valid) begin
          smp_l_d = in_l;
          smp_r_d = in_r;
          state_d = L_STEP;
        end
      end
      L_STEP: begin
        tap_ce  = 1'b1;
        tap_ch  = 1'b0;
        tap_x   = widen(smp_l_q);
        state_d = L_CAP;
      end
      L_CAP: begin
        tap_ch  = 1'b0;
        out_l_d = pcm_val;
        state_d = R_STEP;
      end
      R_STEP: begin
        tap_ce  = 1'b1;
        tap_ch  = 1'b1;
        tap_x   = widen(smp_r_q);
        state_d = R_CAP;
      end
      R_CAP: begin
        tap_ch  = 1'b1;
        out_r_d = pcm_val;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tap_ch_q <= 1'b0;
      smp_l_q  <= '0;
      smp_r_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      tap_ch_q <= tap_ch;
      smp_l_q  <= smp_l_d;
      smp_r_q  <= smp_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
    end
  end

  assign out_l = out_l_q;
  assign out_r = out_r_q;

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Self-checking bench for iir_tap_sequencer: vector table plus a scoreboard of output pairs,
// with hand-written stall and mid-sequence reset sequences.
module tb_iir_tap_sequencer;
  localparam int SW = 16;
  localparam int FB = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [SW-1:0] in_l = '0;
  logic [SW-1:0] in_r = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tap_ce;
  logic          tap_ch;
  logic [39:0]   tap_x;
  logic [39:0]   tap_y = '0;
  logic [SW-1:0] out_l;
  logic [SW-1:0] out_r;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  iir_tap_sequencer #(.SAMPLE_W(SW), .FRAC_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .in_ready(in_ready),
    .tap_ce(tap_ce), .tap_ch(tap_ch), .tap_x(tap_x), .tap_y(tap_y),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [39:0] yl;
    logic [39:0] yr;
    int          stall;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] m_wide(input logic [15:0] s);
    longint t;
    t = longint'($signed(s));
    t = t <<< FB;
    return t[39:0];
  endfunction

  function automatic logic [15:0] m_pcm(input logic [39:0] y);
    longint v;
    v = longint'($signed(y)) >>> FB;
`ifdef IIR_SEQ_ROUND_EN
    v = v + longint'(y[FB-1]);
`endif
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [39:0] junk();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pair(input vec_t v);
    logic [31:0] e;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_tap_ce", 64'(tap_ce), 64'd0);
    in_l = v.l; in_r = v.r; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back({v.el, v.er});
    step();  // L_STEP
    in_l = 16'($urandom); in_r = 16'($urandom);
    tap_y = junk();
    if (v.stall == 0) out_ready = 1'b1;
    chk("lstep_ce", 64'(tap_ce), 64'd1);
    chk("lstep_ch", 64'(tap_ch), 64'd0);
    chk("lstep_x", 64'(tap_x), 64'(m_wide(v.l)));
    chk("lstep_in_ready", 64'(in_ready), 64'd0);
    step();  // L_CAP
    tap_y = v.yl;
    chk("lcap_ce", 64'(tap_ce), 64'd0);
    chk("lcap_x", 64'(tap_x), 64'd0);
    chk("lcap_ch", 64'(tap_ch), 64'd0);
    chk("lcap_out_valid", 64'(out_valid), 64'd0);
    step();  // R_STEP
    tap_y = junk();
    chk("rstep_ce", 64'(tap_ce), 64'd1);
    chk("rstep_ch", 64'(tap_ch), 64'd1);
    chk("rstep_x", 64'(tap_x), 64'(m_wide(v.r)));
    step();  // R_CAP
    tap_y = v.yr;
    chk("rcap_ce", 64'(tap_ce), 64'd0);
    chk("rcap_ch", 64'(tap_ch), 64'd1);
    chk("rcap_x", 64'(tap_x), 64'd0);
    chk("rcap_out_valid", 64'(out_valid), 64'd0);
    step();  // OUT, accept + 5
    tap_y = junk();
    chk("out_valid_t5", 64'(out_valid), 64'd1);
    chk("out_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < v.stall; i++) begin
      in_valid = 1'b1;
      in_l = 16'($urandom); in_r = 16'($urandom);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_tap_ce", 64'(tap_ce), 64'd0);
      chk("stall_hold", 64'({out_l, out_r}), 64'({v.el, v.er}));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("out_l", 64'(out_l), 64'(e[31:16]));
      chk("out_r", 64'(out_r), 64'(e[15:0]));
    end
    step();  // back to IDLE
    out_ready = 1'b0;
    chk("post_out_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_ch_hold", 64'(tap_ch), 64'd1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{16'h1234, 16'hEDCB, 40'h0800000000, 40'hF800000000, 0, 16'h0, 16'h0};
    vecs[1] = '{16'h0001, 16'hFFFF, 40'h0000180000, 40'h0000180000, 0, 16'h0, 16'h0};
    vecs[2] = '{16'h7FFF, 16'h8000, 40'h07FFF00000, 40'hF800000000, 0, 16'h0, 16'h0};
    vecs[3] = '{16'h0000, 16'h0000, 40'h07FFF80000, 40'hFFFFF80000, 0, 16'h0, 16'h0};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 40'h0012345678, 40'hFFEDCBA987, 10, 16'h0, 16'h0};
    vecs[5] = '{16'h8000, 16'h7FFF, 40'h7FFFFFFFFF, 40'h8000000000, 0, 16'h0, 16'h0};
    vecs[6] = '{16'h0100, 16'hFF00, 40'hFFF7FFFFFF, 40'h0008000000, 2, 16'h0, 16'h0};
    for (int i = 0; i < 7; i++) begin
      vecs[i].el = m_pcm(vecs[i].yl);
      vecs[i].er = m_pcm(vecs[i].yr);
    end

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tap_ce", 64'(tap_ce), 64'd0);
    chk("rst_tap_ch", 64'(tap_ch), 64'd0);
    chk("rst_tap_x", 64'(tap_x), 64'd0);
    chk("rst_out_l", 64'(out_l), 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    step();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_pair(vecs[i]);

    // Reset asserted while the right channel is being stepped.
    in_l = 16'h4321; in_r = 16'h1357; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    tap_y = 40'h0001000000;
    step();
    chk("mid_rstep_ce", 64'(tap_ce), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ce", 64'(tap_ce), 64'd0);
    chk("mid_rst_x", 64'(tap_x), 64'd0);
    chk("mid_rst_ch", 64'(tap_ch), 64'd0);
    chk("mid_rst_out_l", 64'(out_l), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("after_rst_out_valid", 64'(out_valid), 64'd0);
      chk("after_rst_tap_ce", 64'(tap_ce), 64'd0);
    end
    v = '{16'h0F0F, 16'hF0F0, 40'h000F0F8000, 40'hFFF0F08000, 0, 16'h0, 16'h0};
    v.el = m_pcm(v.yl);
    v.er = m_pcm(v.yr);
    run_pair(v);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
